// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier arbiter: FSM encoding,
// operand/result widths and requester-index width.
package mult_arb_pkg;

    localparam int OPW  = 16;
    localparam int RESW = 32;
    localparam int IDW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping
// from NREQ-1 back to 0.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_o
);

    always_comb begin
        int              idx;
        logic [NREQ-1:0] sh;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        sh       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sh = req_i >> idx;
            if (!any_o && sh[0]) begin
                winner_o = IDW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external booth_mult between NREQ
// requesters, with a per-operation timeout that aborts a stuck multiply.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [OPW*NREQ-1:0]  op_a_i,
    input  logic [OPW*NREQ-1:0]  op_b_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 res_valid_o,
    output logic [IDW-1:0]       res_id_o,
    output logic [RESW-1:0]      res_o,
    output logic                 res_err_o,
    output logic                 busy_o,
    output logic                 mul_en_o,
    output logic [OPW-1:0]       mul_a_o,
    output logic [OPW-1:0]       mul_b_o,
    input  logic [RESW-1:0]      mul_r_i,
    input  logic                 mul_busy_i
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LIM = CW'(TIMEOUT);

    arb_state_e       state_q;
    logic [IDW-1:0]   ptr_q, ptr_d, id_q, res_id_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q;
    logic             res_valid_q, res_err_q, busy_q, mul_en_q;
    logic [RESW-1:0]  res_q;
    logic [OPW-1:0]   mul_a_q, mul_b_q;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             timeout_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    assign ptr_d       = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (cnt_d == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_q       <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_q  <= ST_ISSUE;
                        ptr_q    <= ptr_d;
                        id_q     <= pick_idx;
                        gnt_q    <= NREQ'(1) << pick_idx;
                        mul_a_q  <= op_a_i[int'(pick_idx)*OPW +: OPW];
                        mul_b_q  <= op_b_i[int'(pick_idx)*OPW +: OPW];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        mul_en_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_d;
                    if (timeout_hit) begin
                        state_q     <= ST_DONE;
                        mul_en_q    <= 1'b0;
                        res_q       <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        res_id_q    <= id_q;
                    end else if (mul_busy_i) begin
                        state_q  <= ST_WAIT;
                        mul_en_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // A finished product wins over a timeout landing on the same cycle.
                    if (!mul_busy_i) begin
                        state_q     <= ST_DONE;
                        res_q       <= mul_r_i;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        res_id_q    <= id_q;
                    end else if (timeout_hit) begin
                        state_q     <= ST_DONE;
                        res_q       <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        res_id_q    <= id_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_o       = res_q;
    assign res_err_o   = res_err_q;
    assign busy_o      = busy_q;
    assign mul_en_o    = mul_en_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural booth_mult stand-in.
module tb_mult_arbiter;
    import mult_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [OPW*NREQ-1:0] op_a, op_b;
    logic [NREQ-1:0]   gnt;
    logic              res_valid, res_err, busy, mul_en;
    logic [IDW-1:0]    res_id;
    logic [RESW-1:0]   res;
    logic [OPW-1:0]    mul_a, mul_b;

    logic              m_busy = 1'b0;
    logic [RESW-1:0]   m_r    = '0;
    logic [RESW-1:0]   m_prod = '0;
    int                m_cnt  = 0;
    int                lat    = 3;
    bit                m_dead = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = 0;
    int a_op[NREQ];
    int b_op[NREQ];

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .gnt_o       (gnt),
        .res_valid_o (res_valid),
        .res_id_o    (res_id),
        .res_o       (res),
        .res_err_o   (res_err),
        .busy_o      (busy),
        .mul_en_o    (mul_en),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_r_i     (m_r),
        .mul_busy_i  (m_busy)
    );

    // Multiplier stand-in: samples en when idle, stays busy for lat cycles, then presents R.
    always @(posedge clk) begin
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_r    <= m_prod;
            end
        end else if (mul_en && !m_dead) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_prod <= 32'(int'($signed(mul_a)) * int'($signed(mul_b)));
        end
    end

    function automatic int rr_model(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (((r >> idx) & NREQ'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    task automatic apply_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*OPW +: OPW] = 16'(a_op[i]);
            op_b[i*OPW +: OPW] = 16'(b_op[i]);
        end
    endtask

    task automatic rand_op(input int i);
        a_op[i] = int'($urandom_range(0, 65535)) - 32768;
        b_op[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_res(output bit ok, output int cyc, output int gnts, output int ens,
                            output bit held);
        logic [OPW-1:0] a0, b0;
        a0 = mul_a; b0 = mul_b;
        ok = 1'b0; cyc = 0; gnts = 0; ens = 1; held = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (gnt !== '0) gnts++;
            if (mul_en === 1'b1) ens++;
            if (mul_a !== a0 || mul_b !== b0) held = 1'b0;
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        for (int i = 0; i < NREQ; i++) rand_op(i);
        apply_ops();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({gnt, res_valid, busy, mul_en} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: gnt=%b res_valid=%b busy=%b mul_en=%b, required all 0",
                     gnt, res_valid, busy, mul_en);
        end
        n_chk++;
        if ({res, res_id, res_err} !== '0) begin
            n_err++;
            $display("FAIL reset_res: res=%h res_id=%0d res_err=%b, required 0", res, res_id, res_err);
        end
        n_chk++;
        if ({mul_a, mul_b} !== '0) begin
            n_err++;
            $display("FAIL reset_ops: mul_a=%h mul_b=%h, required 0", mul_a, mul_b);
        end
        req   = '0;
        rst   = 1'b0;
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok, held; int cyc, gnts, ens;
        a_op[0] = 1000; b_op[0] = 5793;
        apply_ops();
        lat = 3;
        req = 4'b0001;
        wait_gnt(ok);
        n_chk++;
        if (!ok || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL single_gnt: got %b, required 0001", gnt);
            return;
        end
        m_ptr = 1;
        req = '0;
        n_chk++;
        if (mul_a !== 16'd1000 || mul_b !== 16'd5793 || mul_en !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_issue: mul_a=%0d mul_b=%0d mul_en=%b busy=%b, required 1000 5793 1 1",
                     mul_a, mul_b, mul_en, busy);
        end
        wait_res(ok, cyc, gnts, ens, held);
        n_chk++;
        if (!ok || res !== 32'd5793000 || res_id !== 3'd0 || res_err !== 1'b0) begin
            n_err++;
            $display("FAIL single_res: ok=%b res=%0d id=%0d err=%b, required 5793000 0 0",
                     ok, res, res_id, res_err);
        end
        n_chk++;
        if (cyc !== lat + 2 || gnts !== 0 || !held) begin
            n_err++;
            $display("FAIL single_latency: cycles=%0d extra_gnts=%0d held=%b, required %0d 0 1",
                     cyc, gnts, held, lat + 2);
        end
        @(negedge clk);
        n_chk++;
        if (res_valid !== 1'b0 || res !== 32'd5793000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_after: res_valid=%b res=%0d busy=%b, required 0 5793000 0",
                     res_valid, res, busy);
        end
    endtask

    task automatic test_signed();
        bit ok, held; int cyc, gnts, ens;
        a_op[2] = -5793; b_op[2] = 2;
        apply_ops();
        lat = 2;
        req = 4'b0100;
        wait_gnt(ok);
        n_chk++;
        if (!ok || gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL signed_gnt: got %b, required 0100", gnt);
            return;
        end
        m_ptr = 3;
        req = '0;
        wait_res(ok, cyc, gnts, ens, held);
        n_chk++;
        if (!ok || res !== 32'hFFFFD2BE || res_id !== 3'd2 || res_err !== 1'b0) begin
            n_err++;
            $display("FAIL signed_res: ok=%b res=%h id=%0d err=%b, required ffffd2be 2 0",
                     ok, res, res_id, res_err);
        end
    endtask

    task automatic test_fairness();
        bit ok, held; int cyc, gnts, ens, exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) rand_op(i);
        apply_ops();
        req = '1;
        for (int t = 0; t < 5; t++) begin
            lat = int'($urandom_range(1, 5));
            exp = rr_model(req, m_ptr);
            wait_gnt(ok);
            n_chk++;
            if (!ok || gnt !== NREQ'(1 << exp)) begin
                n_err++;
                $display("FAIL fair_gnt[%0d]: got %b, required %b", t, gnt, NREQ'(1 << exp));
                req = '0;
                return;
            end
            m_ptr = (exp + 1) % NREQ;
            wait_res(ok, cyc, gnts, ens, held);
            n_chk++;
            if (!ok || res_id !== 3'(exp) || res !== 32'(a_op[exp] * b_op[exp]) || cyc !== lat + 2) begin
                n_err++;
                $display("FAIL fair_res[%0d]: id=%0d res=%h cycles=%0d, required %0d %h %0d",
                         t, res_id, res, cyc, exp, 32'(a_op[exp] * b_op[exp]), lat + 2);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ptr_wrap();
        bit ok, held; int cyc, gnts, ens, exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) rand_op(i);
        apply_ops();
        lat = 2;
        req = 4'b0010;
        wait_gnt(ok);
        m_ptr = 2;
        req = '0;
        wait_res(ok, cyc, gnts, ens, held);
        req = 4'b0011;
        for (int t = 0; t < 2; t++) begin
            exp = rr_model(req, m_ptr);
            wait_gnt(ok);
            n_chk++;
            if (!ok || gnt !== NREQ'(1 << exp)) begin
                n_err++;
                $display("FAIL ptr2_gnt[%0d]: got %b, required %b", t, gnt, NREQ'(1 << exp));
                req = '0;
                return;
            end
            m_ptr = (exp + 1) % NREQ;
            req[exp] = 1'b0;
            wait_res(ok, cyc, gnts, ens, held);
            n_chk++;
            if (!ok || res_id !== 3'(exp) || res !== 32'(a_op[exp] * b_op[exp])) begin
                n_err++;
                $display("FAIL ptr2_res[%0d]: id=%0d res=%h, required %0d %h",
                         t, res_id, res, exp, 32'(a_op[exp] * b_op[exp]));
            end
        end
    endtask

    task automatic test_timeout();
        bit ok, held; int cyc, gnts, ens;
        m_dead = 1'b1;
        rand_op(3);
        apply_ops();
        req = 4'b1000;
        wait_gnt(ok);
        req = '0;
        m_ptr = 0;
        wait_res(ok, cyc, gnts, ens, held);
        n_chk++;
        if (!ok || res_err !== 1'b1 || res !== '0 || res_id !== 3'd3) begin
            n_err++;
            $display("FAIL timeout_res: ok=%b err=%b res=%h id=%0d, required 1 1 0 3",
                     ok, res_err, res, res_id);
        end
        n_chk++;
        if (cyc !== TIMEOUT || ens !== TIMEOUT) begin
            n_err++;
            $display("FAIL timeout_len: cycles=%0d issue_cycles=%0d, required %0d %0d",
                     cyc, ens, TIMEOUT, TIMEOUT);
        end
        m_dead = 1'b0;
        lat = 4;
        rand_op(0);
        apply_ops();
        req = 4'b0001;
        wait_gnt(ok);
        req = '0;
        m_ptr = 1;
        wait_res(ok, cyc, gnts, ens, held);
        n_chk++;
        if (!ok || res_err !== 1'b0 || res !== 32'(a_op[0] * b_op[0]) || cyc !== lat + 2) begin
            n_err++;
            $display("FAIL timeout_next: err=%b res=%h cycles=%0d, required 0 %h %0d",
                     res_err, res, cyc, 32'(a_op[0] * b_op[0]), lat + 2);
        end
    endtask

    task automatic test_drop();
        bit ok, held; int cyc, gnts, ens, late;
        lat = 5;
        rand_op(0); rand_op(2);
        apply_ops();
        req = 4'b0001;
        wait_gnt(ok);
        req = '0;
        m_ptr = 1;
        fork
            wait_res(ok, cyc, gnts, ens, held);
            begin
                repeat (2) @(negedge clk);
                req[2] = 1'b1;
                @(negedge clk);
                req[2] = 1'b0;
            end
        join
        late = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt !== '0 || busy !== 1'b0) late++;
        end
        n_chk++;
        if (!ok || late !== 0 || res !== 32'(a_op[0] * b_op[0])) begin
            n_err++;
            $display("FAIL drop_ignored: ok=%b stray_cycles=%0d res=%h, required 1 0 %h",
                     ok, late, res, 32'(a_op[0] * b_op[0]));
        end
    endtask

    task automatic test_random();
        bit ok, held; int cyc, gnts, ens, exp;
        logic [NREQ-1:0] nb;
        for (int t = 0; t < 16; t++) begin
            nb = NREQ'($urandom_range(0, 15));
            if ((req | nb) == '0) nb = 4'b0001;
            for (int i = 0; i < NREQ; i++)
                if (nb[i] && !req[i]) rand_op(i);
            apply_ops();
            req = req | nb;
            lat = int'($urandom_range(1, 6));
            exp = rr_model(req, m_ptr);
            wait_gnt(ok);
            n_chk++;
            if (!ok || gnt !== NREQ'(1 << exp)) begin
                n_err++;
                $display("FAIL rand_gnt[%0d]: got %b, required %b (req=%b)", t, gnt, NREQ'(1 << exp), req);
                req = '0;
                return;
            end
            m_ptr = (exp + 1) % NREQ;
            req[exp] = 1'b0;
            wait_res(ok, cyc, gnts, ens, held);
            n_chk++;
            if (!ok || res_id !== 3'(exp) || res !== 32'(a_op[exp] * b_op[exp]) || res_err !== 1'b0
                || cyc !== lat + 2 || !held) begin
                n_err++;
                $display("FAIL rand_res[%0d]: id=%0d res=%h err=%b cycles=%0d held=%b, required %0d %h 0 %0d 1",
                         t, res_id, res, res_err, cyc, held, exp, 32'(a_op[exp] * b_op[exp]), lat + 2);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        bit ok, held; int cyc, gnts, ens, strobes;
        lat = 10;
        rand_op(2);
        apply_ops();
        req = 4'b0100;
        wait_gnt(ok);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        n_chk++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || mul_en !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: busy=%b res_valid=%b mul_en=%b, required 0 0 0",
                     busy, res_valid, mul_en);
        end
        strobes = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid !== 1'b0) strobes++;
        end
        n_chk++;
        if (strobes !== 0) begin
            n_err++;
            $display("FAIL midrst_strobe: res_valid pulses=%0d, required 0", strobes);
        end
        for (int i = 0; i < NREQ; i++) rand_op(i);
        apply_ops();
        lat = 2;
        req = '1;
        wait_gnt(ok);
        n_chk++;
        if (!ok || gnt !== NREQ'(1 << rr_model(4'b1111, m_ptr))) begin
            n_err++;
            $display("FAIL midrst_ptr: got %b, required %b", gnt, NREQ'(1 << rr_model(4'b1111, m_ptr)));
        end
        req = '0;
        wait_res(ok, cyc, gnts, ens, held);
        n_chk++;
        if (!ok || res_id !== 3'd0 || res !== 32'(a_op[0] * b_op[0])) begin
            n_err++;
            $display("FAIL midrst_next: id=%0d res=%h, required 0 %h", res_id, res, 32'(a_op[0] * b_op[0]));
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_op[i] = 0;
            b_op[i] = 0;
        end
        test_reset();
        test_single();
        test_signed();
        test_fairness();
        test_ptr_wrap();
        test_timeout();
        test_drop();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles allowed in ISSUE plus WAIT before an abort.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request level; operands must be held stable while high.
REQ-006 op_a  input  16*NREQ  signed multiplicand, slice i belongs to requester i.
REQ-007 op_b  input  16*NREQ  signed multiplier, slice i belongs to requester i.
REQ-008 gnt  output  NREQ  one-hot, one-cycle pulse marking operand capture.
REQ-009 res_valid  output  1  one-cycle result strobe.
REQ-010 res_id  output  3  index of the requester that owns the result.
REQ-011 res  output  32  signed product, or 0 on abort.
REQ-012 res_err  output  1  abort flag, qualified by res_valid.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 mul_en, mul_a[16], mul_b[16]  outputs  drive the shared booth_mult en, A and B inputs.
REQ-015 mul_r[32], mul_busy  inputs  take the booth_mult R and busy outputs.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE with any req bit high, the FSM SHALL pick a winner, register mul_a, mul_b and id from the winner's slices, and move to ISSUE.
REQ-018 Winner selection SHALL be round-robin: the first set req bit at or after pointer ptr, wrapping from NREQ-1 to 0.
REQ-019 After a grant to requester i, ptr SHALL become (i+1) mod NREQ; ptr SHALL NOT change when no grant is made.
REQ-020 gnt[id] SHALL be high only during the first ISSUE cycle.
REQ-021 A requester whose req is still high in the cycle after its gnt SHALL be treated as a new request.
REQ-022 mul_en SHALL be 1 in every ISSUE cycle and 0 in all other states.
REQ-023 The FSM SHALL move ISSUE->WAIT on the first cycle with mul_busy=1.
REQ-024 The FSM SHALL move WAIT->DONE on the first cycle with mul_busy=0, registering mul_r into res.
REQ-025 In DONE, res_valid SHALL be 1 for exactly one cycle with res_id=id, after which the FSM SHALL return to IDLE.
REQ-026 There SHALL be no back-to-back issue: a new winner is only chosen in IDLE, one cycle after DONE.
REQ-027 The timeout counter SHALL clear on entry to ISSUE and increment in ISSUE and WAIT.
REQ-028 When the timeout counter reaches TIMEOUT, the FSM SHALL go to DONE with res=0 and res_err=1; otherwise res_err=0.
REQ-029 res SHALL hold its last value between strobes.
REQ-030 mul_a and mul_b SHALL hold their values from ISSUE through DONE.
REQ-031 req bits that drop before a grant SHALL be ignored without error.
REQ-032 Request-to-result latency SHALL be 1 (IDLE) + ISSUE cycles + WAIT cycles + 1 (DONE).

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, id=0, counter=0 and drive gnt=0, res_valid=0, res_err=0, res=0, res_id=0, busy=0, mul_en=0, mul_a=0, mul_b=0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no res_valid; a result the multiplier completes after reset SHALL be ignored.

Structure
REQ-035 Package mult_arb_pkg SHALL hold the FSM state encoding, OPW=16, RESW=32 and IDW=3.
REQ-036 Round-robin selection SHALL be implemented in one sub-module, rr_pick, with inputs req and ptr and outputs winner index and any.
REQ-037 No multiplier arithmetic SHALL be implemented in the block; booth_mult stays external.

Verification
REQ-038 Single request: req=0001, a0=1000, b0=5793 -> gnt=0001 once, then res_valid with res=5793000, res_id=0, res_err=0.
REQ-039 Signed operands: a2=-5793, b2=2 -> res=32'hFFFFD2BE, res_id=2.
REQ-040 Fairness: req=1111 held continuously after reset -> grants in order 0,1,2,3,0, each with matching res_id.
REQ-041 Simultaneous requests with pointer at 2: req=0011 with ptr=2 -> requester 0 is granted first, then requester 1.
REQ-042 Timeout: mul_busy tied to 0 -> res_valid after 64 ISSUE cycles with res_err=1 and res=0; next request is served normally.
REQ-043 Mid-operation reset: rst pulsed while in WAIT -> no res_valid, busy=0 the next cycle, ptr=0.
